// File: rtl/tff.sv
// Toggle flip-flop bank: each q bit inverts on a clock edge when its t bit is set.
// Ports: clk, rst (sync, active-high), t[WIDTH] toggle requests, q[WIDTH] state, qn[WIDTH] = ~q.
module tff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Bits are independent: a set t bit flips only its own q bit.
  always_comb begin
    q_d = q_q ^ t;
  end

  // Reset wins over any toggle request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: tb/tb_tff.sv
// Self-checking bench for tff: directed vector table, hand sequences
// and randomized stimulus against a toggle-counting reference model.
module tb_tff;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] t1;
  logic [0:0] q1;
  logic [0:0] qn1;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qn4;

  always #5 clk = ~clk;

  tff u_tff1 (
    .clk (clk),
    .rst (rst),
    .t   (t1),
    .q   (q1),
    .qn  (qn1)
  );

  tff #(
    .WIDTH       (4),
    .RESET_VALUE (RV4)
  ) u_tff4 (
    .clk (clk),
    .rst (rst),
    .t   (t4),
    .q   (q4),
    .qn  (qn4)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: count toggle requests per bit since the last reset;
  // the bit equals its reset value when the count is even.
  int   cnt1;
  int   cnt4 [4];
  bit   valid = 1'b0;
  logic [0:0] exp1;
  logic [3:0] exp4;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic step(input logic r, input logic a, input logic [3:0] b);
    rst = r;
    t1  = a;
    t4  = b;
    @(posedge clk);
    if (r) begin
      cnt1  = 0;
      for (int i = 0; i < 4; i++) cnt4[i] = 0;
      valid = 1'b1;
    end else begin
      cnt1 += int'(a);
      for (int i = 0; i < 4; i++) cnt4[i] += int'(b[i]);
    end
    exp1 = (cnt1 % 2 == 1) ? 1'b1 : 1'b0;
    for (int i = 0; i < 4; i++)
      exp4[i] = RV4[i] ^ (cnt4[i] % 2 == 1);
    #1;
    if (valid) begin
      chk("model_q1",  {3'b0, q1},  {3'b0, exp1});
      chk("model_qn1", {3'b0, qn1}, {3'b0, ~exp1});
      chk("model_q4",  q4,  exp4);
      chk("model_qn4", qn4, ~exp4);
    end
  endtask

  typedef struct {
    logic r;
    logic t;
    logic q;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic t, input logic q);
    vec_t v;
    v.r = r;
    v.t = t;
    v.q = q;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    t1  = 1'b1;
    t4  = 4'hF;

    // reset beats toggle, held for two edges
    tbl.push_back(mk(1, 1, 0));
    tbl.push_back(mk(1, 1, 0));
    // hold
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0));
    // divide by two
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 1, (i % 2 == 0)));
    // mixed pattern 1,0,1,1,0,1 -> 1,1,0,1,1,0
    tbl.push_back(mk(0, 1, 1));
    tbl.push_back(mk(0, 0, 1));
    tbl.push_back(mk(0, 1, 0));
    tbl.push_back(mk(0, 1, 1));
    tbl.push_back(mk(0, 0, 1));
    tbl.push_back(mk(0, 1, 0));
    // reset mid-run
    tbl.push_back(mk(0, 1, 1));
    tbl.push_back(mk(1, 1, 0));
    tbl.push_back(mk(0, 1, 1));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].t, 4'($urandom));
      chk("tbl_q",  {3'b0, q1},  {3'b0, tbl[i].q});
      chk("tbl_qn", {3'b0, qn1}, {3'b0, ~tbl[i].q});
    end

    // WIDTH=4 with non-zero reset value
    step(1, 1, 4'hF);
    chk("w4_reset",  q4,  4'b1010);
    chk("w4_reset_n", qn4, 4'b0101);
    step(0, 0, 4'b0110);
    chk("w4_t0110", q4, 4'b1100);
    step(0, 0, 4'b1111);
    chk("w4_t1111", q4, 4'b0011);
    chk("w4_t1111_n", qn4, 4'b1100);
    step(0, 0, 4'b0000);
    chk("w4_t0000", q4, 4'b0011);

    // reset held across several toggle cycles, then release with toggle
    step(0, 1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'hF);
      chk("rst_hold_q4", q4, 4'b1010);
    end
    step(0, 1, 4'b1001);
    chk("rst_rel_q4", q4, 4'b0011);
    chk("rst_rel_q1", {3'b0, q1}, 4'b0001);

    // randomized run
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), 1'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
